// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and checksum width.
package program_loader_defs;

    localparam int CSUM_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

endpackage

// File: rtl/program_loader.sv
// Loads a framed, checksummed byte stream into instruction RAM as little-endian words
// and holds the CPU in reset until a frame with a correct checksum has been written.
module program_loader
    import program_loader_defs::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    logic [1:0]            state_q, state_d;
    logic [7:0]            count_q, count_d;
    logic [7:0]            word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]      byte_idx_q, byte_idx_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [CSUM_WIDTH-1:0] sum_q, sum_d;
    logic                  error_q, error_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;

    logic                  accept;
    logic [DATA_WIDTH-1:0] word_shifted;

    assign in_ready = (state_q != ST_RUN) && !reload;
    assign accept   = in_valid && in_ready;

    // New bytes enter at the top so that after BYTES shifts the first byte sits in [7:0].
    assign word_shifted = (word_q >> 8) | (DATA_WIDTH'(in_data) << (DATA_WIDTH - 8));

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        sum_d      = sum_q;
        error_d    = error_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        if (reload) begin
            state_d    = ST_IDLE;
            byte_idx_d = '0;
            sum_d      = '0;
            word_d     = '0;
            error_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        count_d    = in_data;
                        word_cnt_d = '0;
                        addr_d     = '0;
                        byte_idx_d = '0;
                        sum_d      = '0;
                        error_d    = 1'b0;
                        state_d    = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        word_d = word_shifted;
                        sum_d  = sum_q + CSUM_WIDTH'(in_data);
                        if (byte_idx_q == LAST_IDX) begin
                            byte_idx_d = '0;
                            mem_we_d   = 1'b1;
                            mem_addr_d = addr_q;
                            mem_data_d = word_shifted;
                            // Word counter is separate from the address so oversize frames wrap the address only.
                            if (word_cnt_q == count_q) begin
                                state_d = ST_CHECK;
                            end else begin
                                word_cnt_d = word_cnt_q + 8'd1;
                                addr_d     = addr_q + ADDR_WIDTH'(1);
                            end
                        end else begin
                            byte_idx_d = byte_idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        if (in_data == sum_q) begin
                            state_d = ST_RUN;
                        end else begin
                            error_d = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            sum_q      <= '0;
            error_q    <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            sum_q      <= sum_d;
            error_q    <= error_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign cpu_reset = (state_q != ST_RUN);
    assign done      = (state_q == ST_RUN);
    assign error     = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: drives framed byte streams and compares RAM writes and
// status outputs against a word/checksum model computed from the frame contents.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        reload = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];

    logic [7:0]  fbytes[$];
    logic [7:0]  exp_addr[$];
    logic [31:0] exp_data[$];
    logic [7:0]  exp_sum;

    program_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data(mem_data), .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n && mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_data);
            wr_cyc.push_back(cyc);
        end
    end

    // Reference: word w is the little-endian combination of bytes 4w..4w+3, stored at w mod 256.
    task automatic build_model(input int h);
        int s;
        logic [31:0] d;
        exp_addr.delete();
        exp_data.delete();
        s = 0;
        for (int w = 0; w <= h; w++) begin
            d = 32'h0;
            for (int j = 0; j < 4; j++) d = d + (32'(fbytes[w*4+j]) << (8*j));
            exp_addr.push_back(8'(w % 256));
            exp_data.push_back(d);
        end
        foreach (fbytes[i]) s += int'(fbytes[i]);
        exp_sum = 8'(s % 256);
    endtask

    task automatic make_random(input int h);
        fbytes.delete();
        for (int i = 0; i < (h + 1) * 4; i++) fbytes.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        bit ok;
        ok = 1'b0;
        if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b;
            #1;
            ok = in_ready;
            @(posedge clk);
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: byte %h not accepted, required acceptance within 64 cycles", b);
        end
    endtask

    task automatic send_frame(input int h, input logic [7:0] cs, input int gap_pct);
        send_byte(8'(h), gap_pct);
        foreach (fbytes[i]) send_byte(fbytes[i], gap_pct);
        send_byte(cs, gap_pct);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        in_valid = 1'b0;
        reload   = 1'b1;
        @(negedge clk);
        reload   = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_cpu_reset: got %b required 1", cpu_reset); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_we: got %b required 0", mem_we); end
        vectors++; if (mem_addr !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_mem_addr: got %h required 00", mem_addr); end
        vectors++; if (mem_data !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mem_data: got %h required 0", mem_data); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b required 0", done); end
        vectors++; if (error !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_error: got %b required 0", error); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_single_word();
        clear_writes();
        fbytes = '{8'h48, 8'h00, 8'h00, 8'h00};
        build_model(0);
        send_frame(0, exp_sum, 0);
        settle();
        vectors++;
        if (wr_addr.size() != 1) begin
            miscompares++; $display("[TB] FAIL single_count: got %0d writes required 1", wr_addr.size());
        end else if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h00000048) begin
            miscompares++; $display("[TB] FAIL single_write: got %h/%h required 00/00000048", wr_addr[0], wr_data[0]);
        end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL single_done: got %b required 1", done); end
        vectors++; if (cpu_reset !== 1'b0) begin miscompares++; $display("[TB] FAIL single_cpu_reset: got %b required 0", cpu_reset); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL single_in_ready: got %b required 0", in_ready); end
        vectors++; if (mem_data !== 32'h00000048) begin miscompares++; $display("[TB] FAIL single_hold: got %h required 00000048", mem_data); end
    endtask

    task automatic test_back_to_back();
        pulse_reload();
        clear_writes();
        fbytes = '{8'h48, 8'h00, 8'h00, 8'h00, 8'hc8, 8'h00, 8'h00, 8'h04, 8'h41, 8'h40, 8'h00, 8'h00};
        build_model(2);
        send_frame(2, exp_sum, 0);
        settle();
        vectors++;
        if (wr_addr.size() != 3) begin
            miscompares++; $display("[TB] FAIL b2b_count: got %0d writes required 3", wr_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
                    miscompares++; $display("[TB] FAIL b2b_write%0d: got %h/%h required %h/%h", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
                end
                if (i > 0 && wr_cyc[i] - wr_cyc[i-1] != 4) begin
                    miscompares++; $display("[TB] FAIL b2b_spacing%0d: got %0d cycles required 4", i, wr_cyc[i] - wr_cyc[i-1]);
                end
            end
        end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_done: got %b required 1", done); end
    endtask

    task automatic test_checksum_error();
        pulse_reload();
        clear_writes();
        fbytes = '{8'h48, 8'h00, 8'h00, 8'h00};
        build_model(0);
        send_frame(0, exp_sum - 8'd1, 0);
        settle();
        vectors++; if (error !== 1'b1) begin miscompares++; $display("[TB] FAIL cserr_error: got %b required 1", error); end
        vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("[TB] FAIL cserr_cpu_reset: got %b required 1", cpu_reset); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL cserr_done: got %b required 0", done); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL cserr_idle: in_ready got %b required 1", in_ready); end
        send_byte(8'h00, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        vectors++; if (error !== 1'b0) begin miscompares++; $display("[TB] FAIL cserr_clear: got %b required 0", error); end
        foreach (fbytes[i]) send_byte(fbytes[i], 0);
        send_byte(exp_sum, 0);
        @(negedge clk);
        in_valid = 1'b0;
        settle();
        vectors++; if (done !== 1'b1 || error !== 1'b0) begin miscompares++; $display("[TB] FAIL cserr_recover: done/error got %b/%b required 1/0", done, error); end
    endtask

    task automatic test_backpressure();
        int h;
        bit bad;
        logic [7:0] cs;
        for (int it = 0; it < 5; it++) begin
            h   = (it == 0) ? 3 : int'($urandom_range(0, 6));
            bad = (it >= 2) && ($urandom_range(0, 1) == 1);
            pulse_reload();
            clear_writes();
            make_random(h);
            build_model(h);
            cs = bad ? exp_sum + 8'd1 : exp_sum;
            send_frame(h, cs, 40);
            settle();
            vectors++;
            if (wr_addr.size() != exp_addr.size()) begin
                miscompares++; $display("[TB] FAIL bp%0d_count: got %0d writes required %0d", it, wr_addr.size(), exp_addr.size());
            end else begin
                foreach (exp_addr[i]) begin
                    if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
                        miscompares++; $display("[TB] FAIL bp%0d_write%0d: got %h/%h required %h/%h", it, i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
                    end
                end
            end
            vectors++;
            if (done !== !bad || error !== bad) begin
                miscompares++; $display("[TB] FAIL bp%0d_status: done/error got %b/%b required %b/%b", it, done, error, !bad, bad);
            end
        end
    endtask

    task automatic test_full_frame();
        pulse_reload();
        clear_writes();
        make_random(255);
        build_model(255);
        send_frame(255, exp_sum, 0);
        settle();
        vectors++;
        if (wr_addr.size() != 256) begin
            miscompares++; $display("[TB] FAIL full_count: got %0d writes required 256", wr_addr.size());
        end else begin
            foreach (exp_addr[i]) begin
                if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
                    miscompares++; $display("[TB] FAIL full_write%0d: got %h/%h required %h/%h", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL full_done: got %b required 1", done); end
    endtask

    task automatic test_reload();
        pulse_reload();
        clear_writes();
        send_byte(8'h01, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(negedge clk);
        reload   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reload_in_ready: got %b required 0", in_ready); end
        @(negedge clk);
        reload   = 1'b0;
        in_valid = 1'b0;
        make_random(1);
        build_model(1);
        send_frame(1, exp_sum, 0);
        settle();
        vectors++;
        if (wr_addr.size() != 2) begin
            miscompares++; $display("[TB] FAIL reload_count: got %0d writes required 2", wr_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
                    miscompares++; $display("[TB] FAIL reload_write%0d: got %h/%h required %h/%h", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL reload_done: got %b required 1", done); end
        pulse_reload();
        #1;
        vectors++; if (cpu_reset !== 1'b1 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL reload_run: cpu_reset/done got %b/%b required 1/0", cpu_reset, done); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reload_idle: in_ready got %b required 1", in_ready); end
    endtask

    task automatic test_async_reset();
        pulse_reload();
        clear_writes();
        make_random(2);
        fbytes[0] = 8'h5A;
        build_model(2);
        send_byte(8'h02, 0);
        for (int i = 0; i < 6; i++) send_byte(fbytes[i], 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        vectors++; if (mem_data !== exp_data[0]) begin miscompares++; $display("[TB] FAIL arst_pre_data: got %h required %h", mem_data, exp_data[0]); end
        #1;
        reset_n = 1'b0;
        #1;
        vectors++; if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_status: cpu_reset/done/error got %b/%b/%b required 1/0/0", cpu_reset, done, error); end
        vectors++; if (mem_we !== 1'b0 || mem_addr !== 8'h00 || mem_data !== 32'h0) begin miscompares++; $display("[TB] FAIL arst_mem: we/addr/data got %b/%h/%h required 0/00/00000000", mem_we, mem_addr, mem_data); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL arst_in_ready: got %b required 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_checksum_error();
        test_backpressure();
        test_full_frame();
        test_reload();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
